// File: rtl/sync_fifo_reader.sv
// Read-side drain engine for a sync_fifo: pops the FIFO head into a 2-entry skid
// buffer and presents it on a registered VALID/BUSY stream, with flush and a transfer counter.
module sync_fifo_reader #(
    parameter int N  = 16,
    parameter int CW = 8
) (
    input  logic          iCLOCK,
    input  logic          iRESET_SYNC,
    input  logic          iREMOVE,
    output logic          oFIFO_REMOVE,
    output logic          oFIFO_RD_EN,
    input  logic [N-1:0]  iFIFO_RD_DATA,
    input  logic          iFIFO_RD_EMPTY,
    output logic          oVALID,
    output logic [N-1:0]  oDATA,
    input  logic          iBUSY,
    output logic [CW-1:0] oXFER_COUNT,
    output logic [1:0]    oDBG_STATE
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Handshake: a word moves downstream on any posedge where oVALID && !iBUSY.
    // The FIFO pops on any posedge where oFIFO_RD_EN is high; the pop never looks
    // at iBUSY, the skid slot absorbs the word popped in the cycle a stall appears.

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  entry0_q, entry0_d;
    logic [N-1:0]  entry1_q, entry1_d;
    logic [CW-1:0] count_q, count_d;

    logic pop;
    logic xfer;

    assign pop  = !iFIFO_RD_EMPTY && (state_q != ST_TWO) && !iREMOVE && !iRESET_SYNC;
    assign xfer = (state_q != ST_EMPTY) && !iBUSY;

    always_comb begin
        state_d  = state_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;

        case (state_q)
            ST_EMPTY: begin
                if (pop) begin
                    state_d  = ST_ONE;
                    entry0_d = iFIFO_RD_DATA;
                end
            end
            ST_ONE: begin
                if (pop && xfer) begin
                    entry0_d = iFIFO_RD_DATA;
                end else if (pop) begin
                    state_d  = ST_TWO;
                    entry1_d = iFIFO_RD_DATA;
                end else if (xfer) begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    state_d  = ST_ONE;
                    entry0_d = entry1_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // A flush drops buffered words but leaves entry0 so oDATA keeps its last value.
        if (iREMOVE) begin
            state_d = ST_EMPTY;
            count_d = '0;
        end else if (xfer) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q  <= ST_EMPTY;
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign oFIFO_REMOVE = iREMOVE;
    assign oFIFO_RD_EN  = pop;
    assign oVALID       = (state_q != ST_EMPTY);
    assign oDATA        = entry0_q;
    assign oXFER_COUNT  = count_q;
    assign oDBG_STATE   = state_q;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: a directed vector table plus hand-written streaming,
// wrap and random-stall sequences against a queue-based FIFO model and scoreboard.
module tb_sync_fifo_reader;

    localparam int N  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          remove_i;
    logic          fifo_remove;
    logic          rd_en;
    logic [N-1:0]  rd_data;
    logic          rd_empty;
    logic          valid;
    logic [N-1:0]  data;
    logic          busy_i;
    logic [CW-1:0] xfer_count;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    sync_fifo_reader #(.N(N), .CW(CW)) dut (
        .iCLOCK         (clk),
        .iRESET_SYNC    (rst_i),
        .iREMOVE        (remove_i),
        .oFIFO_REMOVE   (fifo_remove),
        .oFIFO_RD_EN    (rd_en),
        .iFIFO_RD_DATA  (rd_data),
        .iFIFO_RD_EMPTY (rd_empty),
        .oVALID         (valid),
        .oDATA          (data),
        .iBUSY          (busy_i),
        .oXFER_COUNT    (xfer_count),
        .oDBG_STATE     (dbg_state)
    );

    logic [N-1:0] fq[$];
    logic [N-1:0] exp_q[$];
    int           vec_cnt = 0;
    int           err_cnt = 0;
    logic         force_empty = 1'b0;
    logic         sb_en = 1'b0;

    logic          s_valid, s_rd_en, s_fremove;
    logic [N-1:0]  s_data;
    logic [CW-1:0] s_count;
    logic [1:0]    s_state;

    typedef struct {
        logic          rst, rem, busy, push_en;
        logic [N-1:0]  push_data;
        logic          exp_valid;
        logic [N-1:0]  exp_data;
        logic          exp_rd_en;
        logic [CW-1:0] exp_count;
        logic [1:0]    exp_state;
        logic          exp_fremove;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, sample at negedge, model the FIFO pop at posedge.
    task automatic cyc(input logic rst, input logic rem, input logic busy);
        rst_i    = rst;
        remove_i = rem;
        busy_i   = busy;
        rd_empty = (fq.size() == 0) || force_empty;
        rd_data  = (fq.size() != 0) ? fq[0] : '0;
        @(negedge clk);
        s_valid   = valid;
        s_data    = data;
        s_rd_en   = rd_en;
        s_count   = xfer_count;
        s_state   = dbg_state;
        s_fremove = fifo_remove;
        if (sb_en && s_valid && !busy) begin
            if (exp_q.size() == 0) chk("sb_unexpected_word", 32'(s_data), 32'hFFFF_FFFF);
            else                   chk("sb_data", 32'(s_data), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        if (s_rd_en && fq.size() != 0) void'(fq.pop_front());
        #1;
    endtask

    task automatic push(input logic [N-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    initial begin
        int first_v, last_v, n_v;
        int cnt_model;
        logic hold_prev;
        logic [N-1:0] hold_data;

        rst_i = 1'b1; remove_i = 1'b0; busy_i = 1'b0; rd_empty = 1'b1; rd_data = '0;

        // Reset, stall/skid, flush and remove+xfer as a directed vector table.
        //             rst rem bsy pe  pdata     vld data      rde cnt st  frm
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,4'd0,2'd0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,4'd0,2'd0,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b1,16'h000A,1'b1,4'd0,2'd1,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b1,16'h000A,1'b0,4'd0,2'd2,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b1,16'h000A,1'b0,4'd0,2'd2,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h000A,1'b0,4'd0,2'd2,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h000B,1'b1,4'd1,2'd1,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h000C,1'b0,4'd2,2'd1,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,16'h000D, 1'b0,16'h000C,1'b1,4'd3,2'd0,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,16'h000E, 1'b1,16'h000D,1'b1,4'd3,2'd1,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b1,16'h000F, 1'b1,16'h000D,1'b0,4'd3,2'd2,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,16'h000D,1'b0,4'd3,2'd2,1'b1};
        tbl[12] = '{1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h000D,1'b1,4'd0,2'd0,1'b0};
        tbl[13] = '{1'b0,1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h000F,1'b0,4'd0,2'd1,1'b1};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h000F,1'b0,4'd0,2'd0,1'b0};

        fq.push_back(16'h000A);
        fq.push_back(16'h000B);
        fq.push_back(16'h000C);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].push_en) fq.push_back(tbl[i].push_data);
            cyc(tbl[i].rst, tbl[i].rem, tbl[i].busy);
            chk($sformatf("tbl%0d_valid", i),   32'(s_valid),   32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_data", i),    32'(s_data),    32'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_rd_en", i),   32'(s_rd_en),   32'(tbl[i].exp_rd_en));
            chk($sformatf("tbl%0d_count", i),   32'(s_count),   32'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_state", i),   32'(s_state),   32'(tbl[i].exp_state));
            chk($sformatf("tbl%0d_fremove", i), 32'(s_fremove), 32'(tbl[i].exp_fremove));
        end

        // Streaming 1..8 with no stall: eight consecutive valid cycles, in order.
        fq.delete(); exp_q.delete();
        cyc(1'b1, 1'b0, 1'b0);
        for (int w = 1; w <= 8; w++) push(N'(w));
        sb_en = 1'b1;
        first_v = -1; last_v = -1; n_v = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (s_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                n_v++;
            end
        end
        chk("stream_valid_cycles", 32'(n_v), 32'd8);
        chk("stream_contiguous", 32'(last_v - first_v + 1), 32'd8);
        chk("stream_first_latency", 32'(first_v), 32'd1);
        chk("stream_count", 32'(s_count), 32'd8);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Counter wrap: 17 transfers on a 4-bit counter leave it at 1.
        fq.delete(); exp_q.delete();
        cyc(1'b1, 1'b0, 1'b0);
        for (int w = 0; w < 17; w++) push(N'(16'h0100 + w));
        for (int c = 0; c < 30; c++) cyc(1'b0, 1'b0, 1'b0);
        chk("wrap_count", 32'(s_count), 32'd1);
        chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Random stall / empty-flicker stress with scoreboard and hold-stability checks.
        fq.delete(); exp_q.delete();
        cyc(1'b1, 1'b0, 1'b0);
        cnt_model = 0;
        hold_prev = 1'b0;
        hold_data = '0;
        for (int c = 0; c < 400; c++) begin
            logic b;
            if ($urandom_range(0, 2) == 0 && fq.size() < 8) push(N'($urandom_range(0, 16'hFFFF)));
            force_empty = ($urandom_range(0, 3) == 0);
            b = 1'($urandom_range(0, 1));
            cyc(1'b0, 1'b0, b);
            if (hold_prev) begin
                chk("stress_hold_valid", 32'(s_valid), 32'd1);
                chk("stress_hold_data", 32'(s_data), 32'(hold_data));
            end
            if (s_valid && !b) cnt_model++;
            hold_prev = s_valid && b;
            hold_data = s_data;
        end
        force_empty = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (s_valid) cnt_model++;
        end
        chk("stress_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("stress_count", 32'(s_count), 32'(cnt_model % 16));
        chk("stress_drained", 32'(s_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
